// File: rtl/peripheral_div_param_if.sv
// rtl/peripheral_div_param_if.sv - peripheral bus bundle for the divider peripheral
interface peripheral_div_param_if #(
  parameter int WIDTH = 16
);
  logic             cs;
  logic [3:0]       addr;
  logic             rd;
  logic             wr;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] d_out;

  modport master (output cs, addr, rd, wr, d_in, input d_out);
  modport slave  (input cs, addr, rd, wr, d_in, output d_out);
endinterface

// File: rtl/peripheral_div_param.sv
// rtl/peripheral_div_param.sv - memory-mapped restoring divider, signed/unsigned, one quotient bit per clock
module peripheral_div_param #(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  peripheral_div_param_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [3:0] ADDR_A = 4'h0, ADDR_B = 4'h2, ADDR_CTRL = 4'h4,
                         ADDR_STATUS = 4'h6, ADDR_Q = 4'h8, ADDR_R = 4'hA;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, q_q, q_d, r_q, r_d, dout_q, dout_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, magb_q, magb_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgn_q, sgn_d, opsgn_q, opsgn_d;
  logic             done_q, done_d, dz_q, dz_d, ovf_q, ovf_d;

  logic             wr_en, rd_en, start, busy;
  logic [WIDTH:0]   trial, diff;
  logic [WIDTH-1:0] status, rd_data;
  logic             q_neg, r_neg;

  assign wr_en = bus.cs & bus.wr;
  assign rd_en = bus.cs & bus.rd;
  // A start arriving while an operation runs is simply not accepted here.
  assign start = wr_en && (bus.addr == ADDR_CTRL) && bus.d_in[0] && (state_q == S_IDLE);
  assign busy  = (state_q != S_IDLE);
  assign status = WIDTH'({sgn_q, ovf_q, dz_q, busy, done_q});
  assign bus.d_out = dout_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q <= '0; b_q <= '0; q_q <= '0; r_q <= '0; dout_q <= '0;
      opa_q <= '0; opb_q <= '0; magb_q <= '0; quo_q <= '0; rem_q <= '0;
      cnt_q <= '0; sgn_q <= 1'b0; opsgn_q <= 1'b0;
      done_q <= 1'b0; dz_q <= 1'b0; ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d; b_q <= b_d; q_q <= q_d; r_q <= r_d; dout_q <= dout_d;
      opa_q <= opa_d; opb_q <= opb_d; magb_q <= magb_d; quo_q <= quo_d; rem_q <= rem_d;
      cnt_q <= cnt_d; sgn_q <= sgn_d; opsgn_q <= opsgn_d;
      done_q <= done_d; dz_q <= dz_d; ovf_q <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (b_q == '0) ? S_FIX : S_RUN;
      S_RUN:  if (cnt_q == '0) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_d = a_q; b_d = b_q; sgn_d = sgn_q;
    q_d = q_q; r_d = r_q;
    opa_d = opa_q; opb_d = opb_q; opsgn_d = opsgn_q; magb_d = magb_q;
    quo_d = quo_q; rem_d = rem_q; cnt_d = cnt_q;
    done_d = done_q; dz_d = dz_q; ovf_d = ovf_q;

    trial = {rem_q, quo_q[WIDTH-1]};
    diff  = trial - {1'b0, magb_q};
    q_neg = opsgn_q & (opa_q[WIDTH-1] ^ opb_q[WIDTH-1]);
    r_neg = opsgn_q & opa_q[WIDTH-1];

    if (wr_en && bus.addr == ADDR_A)    a_d   = bus.d_in;
    if (wr_en && bus.addr == ADDR_B)    b_d   = bus.d_in;
    if (wr_en && bus.addr == ADDR_CTRL) sgn_d = bus.d_in[1];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          opa_d   = a_q;
          opb_d   = b_q;
          opsgn_d = bus.d_in[1];
          done_d  = 1'b0;
          ovf_d   = 1'b0;
          dz_d    = (b_q == '0);
          // Dividend magnitude is shifted out of quo while quotient bits shift in.
          quo_d   = (bus.d_in[1] && a_q[WIDTH-1]) ? -a_q : a_q;
          magb_d  = (bus.d_in[1] && b_q[WIDTH-1]) ? -b_q : b_q;
          rem_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
        end
      end
      S_RUN: begin
        rem_d = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        cnt_d = cnt_q - 1'b1;
      end
      S_FIX: begin
        done_d = 1'b1;
        if (dz_q) begin
          q_d = '1;
          r_d = opa_q;
        end else begin
          // MIN / -1 needs no special datapath: negating MIN wraps back to MIN.
          q_d   = q_neg ? -quo_q : quo_q;
          r_d   = r_neg ? -rem_q : rem_q;
          ovf_d = opsgn_q && (opa_q == {1'b1, {(WIDTH-1){1'b0}}}) && (opb_q == '1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    case (bus.addr)
      ADDR_A:      rd_data = a_q;
      ADDR_B:      rd_data = b_q;
      ADDR_STATUS: rd_data = status;
      ADDR_Q:      rd_data = q_q;
      ADDR_R:      rd_data = r_q;
      default:     rd_data = '0;
    endcase
    dout_d = rd_en ? rd_data : dout_q;
  end
endmodule

// File: doc/peripheral_div_param.md
# peripheral_div_param

Parametrised memory-mapped integer divider peripheral on the processor's peripheral bus (chip-select / address / read / write strobes). Successor to the fixed 16-bit unsigned divider peripheral:
- generic operand width
- signed and unsigned modes
- quotient and remainder readback
- divide-by-zero and overflow status
- busy-protected operand shadowing

Computes one quotient bit per clock using a restoring algorithm.

## Interface
- WIDTH, 16: operand, result and data-bus width; legal range 4..32.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cs  in  1  chip select; gates rd/wr.
- addr  in  4  register address (even values only; odd and unmapped values decode to nothing).
- rd  in  1  read strobe.
- wr  in  1  write strobe.
- d_in  in  WIDTH  write data.
- d_out  out  WIDTH  registered read data.

## Operation
Register map:
- 0x0 A (RW): dividend shadow.
- 0x2 B (RW): divisor shadow.
- 0x4 CTRL (W): bit0 start (self-clearing, not stored), bit1 signed mode (stored; reads back in STATUS bit4).
- 0x6 STATUS (R): bit0 done, bit1 busy, bit2 dz (divide by zero), bit3 ovf, bit4 signed; other bits 0.
- 0x8 Q (R): quotient.
- 0xA R (R): remainder.

Bus rules:
- Write occurs on the rising edge with cs&wr.
- A, B and the signed bit may be written at any time, including while busy. The running operation is unaffected because operands are copied at start.

State machine:
- **IDLE**: a CTRL write with bit0=1 is the start. At the start edge the block latches A, B and mode, clears done/dz/ovf and sets busy.
  - B==0: goes to FIX with dz=1.
  - Otherwise: loads the magnitudes (absolute values if signed) and goes to RUN with an iteration counter of WIDTH-1.
- **RUN**: one restoring shift/subtract per cycle. Partial remainder is WIDTH+1 bits. Counter decrements; at 0 the next state is FIX.
- **FIX**: applies signs and writes Q and R, sets done, clears busy, returns to IDLE.
  - Signed mode truncates toward zero; the remainder takes the dividend's sign.
  - dz: Q = all ones, R = dividend (raw A), regardless of mode.
  - Signed most-negative / -1: Q = most-negative (wraps), R=0, ovf=1.
- A start while busy is ignored; the signed bit in the same write is still stored.
- done stays set until the next accepted start.

Reset:
- All registers, d_out, Q, R and STATUS go to 0; state goes to IDLE.
- Asserting reset mid-operation aborts it; no result is produced.

## Timing
Read port:
- d_out loads the addressed register on the rising edge with cs&rd (one-cycle read latency) and holds otherwise.
- If rd and wr fall on the same edge, d_out returns the pre-write value.
- Unmapped addresses read as 0.

Latency, with the start accepted at edge E0:
- busy=1 after E0.
- Normal operation: RUN occupies edges E1..E(WIDTH), and FIX at edge E(WIDTH+1) makes done=1, busy=0, Q/R valid. For WIDTH=16 this is 17 cycles.
- dz: FIX at E1, so done after E1.
- The earliest new start is the edge after done is set.

## Test plan
All cases use WIDTH=16.
- **Unsigned divide**: write A=10, B=4, CTRL=0x1. Poll STATUS → busy for 17 edges, then done=1; Q=2, R=2.
- **Signed divide**: A=0xFFF9 (-7), B=2, CTRL=0x3 → Q=0xFFFD (-3), R=0xFFFF (-1), STATUS=0x11. Repeat unsigned (CTRL=0x1) → Q=0x7FFC, R=0x0001.
- **Divide by zero**: A=35, B=0, CTRL=0x1 → done after 1 cycle; STATUS=0x05, Q=0xFFFF, R=35.
- **Signed overflow**: A=0x8000, B=0xFFFF, CTRL=0x3 → Q=0x8000, R=0, STATUS=0x19.
- **Start while busy**: A=1000, B=7, start; 3 cycles later write A=5 and CTRL=0x1 → first result completes unchanged (Q=142, R=6) at the original done time. A then reads 5, and no second operation runs.
- **Reset mid-operation**: start 100/3, assert rst at cycle 5 → all outputs and registers 0, STATUS=0. After release, a new start of 100/3 gives Q=33, R=1.
